// File: rtl/lock_pkg.sv
// lock_pkg: shared types and constants for the serial code lock.
//   lock_state_e : lock FSM states (COLLECT, OPEN, ALARM)
//   FAIL_W       : width of the consecutive-failure counter
//   OPEN_W       : width of the open-duration timer (covers 1..255)
package lock_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    OPEN    = 2'd1,
    ALARM   = 2'd2
  } lock_state_e;

  localparam int FAIL_W = 4;
  localparam int OPEN_W = 8;

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that times how long the lock stays open.
//   clk      : clock
//   reset    : synchronous active-high reset
//   load     : load load_val (takes priority over enable)
//   enable   : count down by one while non-zero
//   load_val : number of cycles to run
//   done     : high during the last counted cycle (terminal count of 1)
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A value of 1 means this is the final cycle; the owner leaves OPEN on
  // this edge, giving exactly load_val cycles of OPEN.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/seq_code_lock.sv
// seq_code_lock: serial code lock with programmable code and failure lockout.
//   clk        : clock
//   reset      : synchronous active-high reset
//   code       : serial code bit, MSB first, qualified by code_valid
//   code_valid : code is meaningful this cycle
//   prog_en    : load prog_code as the stored code (honoured only while open)
//   prog_code  : new code value
//   openlock   : high while open (registered)
//   alarm      : high while locked out (registered)
//   fail_cnt   : consecutive failed attempts, saturating at MAX_FAIL
//
// state   | meaning
// COLLECT | shifting in code bits, compare after CODE_LEN bits
// OPEN    | lock open for OPEN_CYCLES cycles, code may be reprogrammed
// ALARM   | lockout, only reset leaves
module seq_code_lock
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN    = 4,
  parameter logic [CODE_LEN-1:0] RESET_CODE  = 4'b0110,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  OPEN_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                code,
  input  logic                code_valid,
  input  logic                prog_en,
  input  logic [CODE_LEN-1:0] prog_code,
  output logic                openlock,
  output logic                alarm,
  output logic [FAIL_W-1:0]   fail_cnt
);

  localparam int CNT_W = $clog2(CODE_LEN + 1);

  lock_state_e         state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [CODE_LEN-1:0] attempt_q;
  logic [CODE_LEN-1:0] attempt_d;
  logic [CODE_LEN-1:0] stored_q;
  logic [FAIL_W-1:0]   fail_q;
  logic [FAIL_W-1:0]   fail_d;
  logic                openlock_q;
  logic                alarm_q;
  logic                sample;
  logic                last_bit;
  logic                match;
  logic                timer_done;

  always_comb begin
    attempt_d = {attempt_q[CODE_LEN-2:0], code};
    sample    = (state_q == COLLECT) && code_valid;
    last_bit  = (bit_cnt_q == CNT_W'(CODE_LEN - 1));
    // Compare against the shifted value so the deciding bit is included.
    match     = sample && last_bit && (attempt_d == stored_q);
    fail_d    = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + FAIL_W'(1);
  end

  lock_timer #(.W(OPEN_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (match),
    .enable   (state_q == OPEN),
    .load_val (OPEN_W'(OPEN_CYCLES)),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      bit_cnt_q  <= '0;
      attempt_q  <= '0;
      stored_q   <= RESET_CODE;
      fail_q     <= '0;
      openlock_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (sample) begin
            attempt_q <= attempt_d;
            if (last_bit) begin
              bit_cnt_q <= '0;
              if (match) begin
                state_q    <= OPEN;
                fail_q     <= '0;
                openlock_q <= 1'b1;
              end else begin
                fail_q <= fail_d;
                if (fail_d == FAIL_W'(MAX_FAIL)) begin
                  state_q <= ALARM;
                  alarm_q <= 1'b1;
                end
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        OPEN: begin
          if (prog_en) begin
            stored_q <= prog_code;
          end
          if (timer_done) begin
            state_q    <= COLLECT;
            bit_cnt_q  <= '0;
            openlock_q <= 1'b0;
          end
        end
        ALARM: begin
        end
        default: begin
          state_q    <= COLLECT;
          openlock_q <= 1'b0;
          alarm_q    <= 1'b0;
        end
      endcase
    end
  end

  assign openlock = openlock_q;
  assign alarm    = alarm_q;
  assign fail_cnt = fail_q;

endmodule
